// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - instruction-in and ALU-out handshake bundle for the issue stage
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            in_opcode;
  logic [5:0]            in_funct;
  logic [DATA_WIDTH-1:0] in_rs_val;
  logic [DATA_WIDTH-1:0] in_rt_val;
  logic [15:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [2:0]            ALUop;

  // master: decode front-end plus ALU consumer; slave: the issue stage itself
  modport master (
    output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, out_ready,
    input  in_ready, out_valid, A, B, ALUop
  );

  modport slave (
    input  in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, out_ready,
    output in_ready, out_valid, A, B, ALUop
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - MIPS op decode and operand formation into a 2-entry registered skid buffer
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  alu_issue_stage_if.slave     bus,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] issued_cnt,
  output logic [CNT_WIDTH-1:0] illegal_cnt
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                state, state_next;
  logic                  in_ready_q;
  logic                  dec_legal;
  logic [2:0]            dec_op;
  logic [DATA_WIDTH-1:0] dec_a, dec_b;
  logic [DATA_WIDTH-1:0] imm_se, imm_ze, imm_lui;
  logic [DATA_WIDTH-1:0] or_a, or_b, sk_a, sk_b;
  logic [2:0]            or_op, sk_op;
  logic                  in_fire, out_fire, legal_fire, illegal_fire;
  logic                  load_or_in, load_or_sk, load_sk;

  assign imm_se  = {{(DATA_WIDTH-16){bus.in_imm[15]}}, bus.in_imm};
  assign imm_ze  = {{(DATA_WIDTH-16){1'b0}}, bus.in_imm};
  assign imm_lui = imm_ze << 16;

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = ALU_ADD;
    dec_a     = bus.in_rs_val;
    dec_b     = bus.in_rt_val;
    case (bus.in_opcode)
      6'h00: begin
        case (bus.in_funct)
          6'h20, 6'h21: dec_op = ALU_ADD;
          6'h22, 6'h23: dec_op = ALU_SUB;
          6'h24:        dec_op = ALU_AND;
          6'h25:        dec_op = ALU_OR;
          6'h2A:        dec_op = ALU_SLT;
          default:      dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin dec_op = ALU_ADD; dec_b = imm_se; end
      6'h0A:        begin dec_op = ALU_SLT; dec_b = imm_se; end
      6'h0C:        begin dec_op = ALU_AND; dec_b = imm_ze; end
      6'h0D:        begin dec_op = ALU_OR;  dec_b = imm_ze; end
      6'h04, 6'h05: dec_op = ALU_SUB;
      6'h0F:        begin dec_op = ALU_OR; dec_a = '0; dec_b = imm_lui; end
      default:      dec_legal = 1'b0;
    endcase
  end

  assign in_fire      = bus.in_valid & in_ready_q;
  assign out_fire     = bus.out_valid & bus.out_ready;
  assign legal_fire   = in_fire & dec_legal;
  assign illegal_fire = in_fire & ~dec_legal;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= EMPTY;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_or_in = 1'b0;
    load_or_sk = 1'b0;
    load_sk    = 1'b0;
    case (state)
      EMPTY: if (legal_fire) begin load_or_in = 1'b1; state_next = ONE; end
      ONE: begin
        if (legal_fire && out_fire)  load_or_in = 1'b1;
        else if (legal_fire) begin load_sk = 1'b1; state_next = FULL; end
        else if (out_fire)   state_next = EMPTY;
      end
      FULL: if (out_fire) begin load_or_sk = 1'b1; state_next = ONE; end
      default: state_next = EMPTY;
    endcase
  end

  // in_ready is a flop so upstream never sees a combinational path from out_ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) in_ready_q <= 1'b1;
    else         in_ready_q <= (state_next != FULL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      or_a  <= '0;
      or_b  <= '0;
      or_op <= ALU_AND;
      sk_a  <= '0;
      sk_b  <= '0;
      sk_op <= ALU_AND;
    end else begin
      if (load_or_in) begin
        or_a  <= dec_a;
        or_b  <= dec_b;
        or_op <= dec_op;
      end else if (load_or_sk) begin
        or_a  <= sk_a;
        or_b  <= sk_b;
        or_op <= sk_op;
      end
      if (load_sk) begin
        sk_a  <= dec_a;
        sk_b  <= dec_b;
        sk_op <= dec_op;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      illegal     <= 1'b0;
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      illegal <= illegal_fire;
      if (out_fire) issued_cnt <= issued_cnt + 1'b1;
      if (illegal_fire && (illegal_cnt != {CNT_WIDTH{1'b1}})) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.A         = or_a;
  assign bus.B         = or_b;
  assign bus.ALUop     = or_op;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and randomized checks of alu_issue_stage against a decode-queue model
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        illegal;
  logic [15:0] issued_cnt, illegal_cnt;

  alu_issue_stage_if #(.DATA_WIDTH(32)) bus ();

  alu_issue_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .illegal     (illegal),
    .issued_cnt  (issued_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  int          exp_issued = 0;
  int          exp_illegal = 0;
  bit          pend_illegal = 0;
  bit          hold_prev = 0;
  exp_t        prev_out;
  logic [11:0] legal_tbl [0:16] = '{
    {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24},
    {6'h00, 6'h25}, {6'h00, 6'h2A}, {6'h08, 6'h00}, {6'h09, 6'h00}, {6'h23, 6'h00},
    {6'h2B, 6'h00}, {6'h0A, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h04, 6'h00},
    {6'h05, 6'h00}, {6'h0F, 6'h00}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: ALU encodings AND=0 OR=1 ADD=2 SUB=6 SLT=7
  function automatic bit ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                    input logic [31:0] rs, input logic [31:0] rt,
                                    input logic [15:0] imm, output exp_t e);
    int signed   simm = $signed(imm);
    logic [31:0] se   = simm;
    logic [31:0] ze   = 32'(imm);
    e.a = rs; e.b = rt; e.op = 3'd2;
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21)      e.op = 3'd2;
      else if (fn == 6'h22 || fn == 6'h23) e.op = 3'd6;
      else if (fn == 6'h24)                e.op = 3'd0;
      else if (fn == 6'h25)                e.op = 3'd1;
      else if (fn == 6'h2A)                e.op = 3'd7;
      else return 1'b0;
      return 1'b1;
    end
    case (op)
      6'h08, 6'h09, 6'h23, 6'h2B: begin e.op = 3'd2; e.b = se; end
      6'h0A: begin e.op = 3'd7; e.b = se; end
      6'h0C: begin e.op = 3'd0; e.b = ze; end
      6'h0D: begin e.op = 3'd1; e.b = ze; end
      6'h04, 6'h05: e.op = 3'd6;
      6'h0F: begin e.op = 3'd1; e.a = 32'd0; e.b = ze * 32'd65536; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // One clock: drive at negedge, check model vs DUT, then account for the coming edge
  task automatic cycle(input bit iv, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                       input bit ordy, output bit in_fire);
    exp_t e;
    bit   lg, out_fire;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_opcode = op;
    bus.in_funct  = fn;
    bus.in_rs_val = rs;
    bus.in_rt_val = rt;
    bus.in_imm    = imm;
    bus.out_ready = ordy;
    #1;
    check("illegal_pulse", illegal, pend_illegal);
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("in_ready", bus.in_ready, exp_q.size() < 2);
    check("issued_cnt", issued_cnt, exp_issued[15:0]);
    check("illegal_cnt", illegal_cnt, exp_illegal[15:0]);
    if (bus.out_valid && exp_q.size() != 0) begin
      check("A", bus.A, exp_q[0].a);
      check("B", bus.B, exp_q[0].b);
      check("ALUop", bus.ALUop, exp_q[0].op);
    end
    if (hold_prev && bus.out_valid) begin
      check("hold_A", bus.A, prev_out.a);
      check("hold_B", bus.B, prev_out.b);
      check("hold_op", bus.ALUop, prev_out.op);
    end
    in_fire   = iv & bus.in_ready;
    out_fire  = bus.out_valid & ordy;
    hold_prev = bus.out_valid & ~ordy;
    prev_out.a = bus.A; prev_out.b = bus.B; prev_out.op = bus.ALUop;
    if (out_fire && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_issued++;
    end
    pend_illegal = 1'b0;
    if (in_fire) begin
      lg = ref_decode(op, fn, rs, rt, imm, e);
      if (lg) exp_q.push_back(e);
      else begin
        if (exp_illegal < 65535) exp_illegal++;
        pend_illegal = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_A", bus.A, 0);
    check("rst_B", bus.B, 0);
    check("rst_ALUop", bus.ALUop, 0);
    check("rst_illegal", illegal, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_illcnt", illegal_cnt, 0);
    exp_q.delete();
    exp_issued = 0; exp_illegal = 0; pend_illegal = 0; hold_prev = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain(input int bound);
    bit f;
    for (int i = 0; i < bound && exp_q.size() != 0; i++)
      cycle(1'b0, 6'h3F, 6'h3F, 32'd0, 32'd0, 16'd0, 1'b1, f);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit          f;
    int          accepted, cycles;
    bit          pending;
    logic [5:0]  r_op, r_fn;
    logic [31:0] r_rs, r_rt;
    logic [15:0] r_imm;
    bus.in_valid = 0; bus.in_opcode = 0; bus.in_funct = 0;
    bus.in_rs_val = 0; bus.in_rt_val = 0; bus.in_imm = 0; bus.out_ready = 0;

    // addi sign-extends and reaches the ALU one cycle later
    do_reset();
    cycle(1'b1, 6'h08, 6'h00, 32'd5, 32'd0, 16'hFFFF, 1'b1, f);
    cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b1, f);
    check("t1_valid", bus.out_valid, 1);
    check("t1_A", bus.A, 32'd5);
    check("t1_B", bus.B, 32'hFFFF_FFFF);
    check("t1_op", bus.ALUop, 3'b010);

    // LUI then ori
    do_reset();
    cycle(1'b1, 6'h0F, 6'h00, 32'hDEAD_BEEF, 32'd0, 16'h1234, 1'b1, f);
    cycle(1'b1, 6'h0D, 6'h00, 32'd0, 32'd0, 16'h8000, 1'b1, f);
    check("t2_lui_B", bus.B, 32'h1234_0000);
    check("t2_lui_A", bus.A, 32'd0);
    check("t2_lui_op", bus.ALUop, 3'b001);
    cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b1, f);
    check("t2_ori_B", bus.B, 32'h0000_8000);
    check("t2_ori_op", bus.ALUop, 3'b001);

    // backpressure fills both entries, third op waits
    do_reset();
    cycle(1'b1, 6'h00, 6'h20, 32'd1, 32'd2, 16'd0, 1'b0, f);
    check("t3_acc1", f, 1);
    cycle(1'b1, 6'h00, 6'h22, 32'd3, 32'd4, 16'd0, 1'b0, f);
    check("t3_acc2", f, 1);
    cycle(1'b1, 6'h00, 6'h2A, 32'd5, 32'd6, 16'd0, 1'b0, f);
    check("t3_blocked", f, 0);
    for (int i = 0; i < 10 && !f; i++)
      cycle(1'b1, 6'h00, 6'h2A, 32'd5, 32'd6, 16'd0, 1'b1, f);
    check("t3_acc3", f, 1);
    drain(10);
    cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b1, f);
    check("t3_issued", issued_cnt, 16'd3);

    // illegal funct
    do_reset();
    cycle(1'b1, 6'h00, 6'h3F, 32'd7, 32'd8, 16'd0, 1'b1, f);
    cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b1, f);
    check("t4_pulse", illegal, 1);
    check("t4_noval", bus.out_valid, 0);
    cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b1, f);
    check("t4_pulse_end", illegal, 0);
    check("t4_cnt", illegal_cnt, 16'd1);

    // reset while FULL
    do_reset();
    cycle(1'b1, 6'h0C, 6'h00, 32'hFF, 32'd0, 16'h0F0F, 1'b0, f);
    cycle(1'b1, 6'h09, 6'h00, 32'h10, 32'd0, 16'h0020, 1'b0, f);
    cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b0, f);
    check("t5_full", bus.in_ready, 0);
    do_reset();
    repeat (4) cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b1, f);

    // randomized traffic
    do_reset();
    accepted = 0; cycles = 0; pending = 0;
    r_op = 0; r_fn = 0; r_rs = 0; r_rt = 0; r_imm = 0;
    while (accepted < 10000 && cycles < 60000) begin
      if (!pending) begin
        if ($urandom_range(0, 9) < 8) begin
          logic [11:0] ent = legal_tbl[$urandom_range(0, 16)];
          r_op = ent[11:6];
          r_fn = (r_op == 6'h00) ? ent[5:0] : 6'($urandom);
        end else begin
          r_op = 6'($urandom);
          r_fn = 6'($urandom);
        end
        r_rs = $urandom; r_rt = $urandom; r_imm = 16'($urandom);
        pending = 1'b1;
      end
      cycle(pending && ($urandom_range(0, 3) != 0), r_op, r_fn, r_rs, r_rt, r_imm,
            $urandom_range(0, 3) != 0, f);
      if (f) begin accepted++; pending = 1'b0; end
      cycles++;
    end
    check("t6_ops_done", accepted >= 10000, 1);
    drain(20);
    cycle(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b1, f);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
